// File: rtl/divider_seq_if.sv
// Start/ready handshake bundle shared by the sequential divider and multiplier.
// The controller side uses the master modport, the arithmetic unit uses slave.
interface divider_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             ready;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  Quotient, Remainder, ready, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output Quotient, Remainder, ready, div_by_zero
  );
endinterface

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// A start always reloads the operands, even mid-operation, so a controller can
// abandon a division simply by issuing a new one. The iteration counter doubles
// as the busy flag: it parks at WIDTH when idle.
module divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  divider_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             busy;

  assign busy = (cnt_q != CNT_DONE);

  // One restoring step: shift the next dividend bit in, keep the difference only if it did not go negative
  always_comb begin
    shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = shifted - {1'b0, d_q};
    r_step  = shifted;
    q_step  = {q_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_step = trial;
      q_step = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state selection: load wins over iterate, results publish on the last step
  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (bus.start) begin
      r_d   = '0;
      q_d   = bus.A;
      d_d   = bus.B;
      cnt_d = '0;
      dbz_d = (bus.B == '0);
    end else if (busy) begin
      r_d   = r_step;
      q_d   = q_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        quot_d = q_step;
        rem_d  = r_step[WIDTH-1:0];
      end
    end
  end

  // State registers; reset abandons any division in flight and parks the counter at idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= CNT_DONE;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign bus.Quotient    = quot_q;
  assign bus.Remainder   = rem_q;
  assign bus.ready       = ~busy;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corner cases followed by a
// randomized sweep, all results compared against plain integer division.
module tb_divider_seq;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  divider_seq_if #(.WIDTH(WIDTH)) bus ();

  divider_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int misses  = 0;

  // Values the outputs must hold while a new division is running
  logic [WIDTH-1:0] prevQuot = '0;
  logic [WIDTH-1:0] prevRem  = '0;

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      misses++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: plain arithmetic division, all-ones quotient and remainder=A on zero divisor
  function automatic void refDivide(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = WIDTH'(int'(a) / int'(b));
      r = WIDTH'(int'(a) % int'(b));
    end
  endfunction

  // Drive one start pulse; returns 1 ns after the load edge
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_holdQ"}, 32'(bus.Quotient), 32'(prevQuot));
    checkOutput({tag, "_holdR"}, 32'(bus.Remainder), 32'(prevRem));
  endtask

  // After a load edge: wait for ready (bounded), scrambling operand inputs meanwhile, then check
  task automatic finishOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    int edges;
    logic [WIDTH-1:0] eq, er;
    checkOutput({tag, "_busy"}, 32'(bus.ready), 32'd0);
    checkOutput({tag, "_dbzLoad"}, 32'(bus.div_by_zero), 32'(b == 0));
    checkHeld(tag);
    edges = 0;
    while (bus.ready !== 1'b1 && edges < 20) begin
      bus.A = WIDTH'($urandom);
      bus.B = WIDTH'($urandom);
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'(WIDTH));
    refDivide(a, b, eq, er);
    checkOutput({tag, "_quot"}, 32'(bus.Quotient), 32'(eq));
    checkOutput({tag, "_rem"}, 32'(bus.Remainder), 32'(er));
    checkOutput({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(b == 0));
    if (b != 0) begin
      checkOutput({tag, "_invariant"}, 32'(bus.Quotient) * 32'(b) + 32'(bus.Remainder), 32'(a));
      checkOutput({tag, "_remLtB"}, 32'(bus.Remainder < b), 32'd1);
    end
    prevQuot = eq;
    prevRem  = er;
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    applyStimulus(a, b);
    finishOp(a, b, tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.ready), 32'd1);
    checkOutput({tag, "_quot"}, 32'(bus.Quotient), 32'd0);
    checkOutput({tag, "_rem"}, 32'(bus.Remainder), 32'd0);
    checkOutput({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    prevQuot = '0;
    prevRem  = '0;
  endtask

  // Main stimulus sequence
  initial begin
    logic [WIDTH-1:0] ra, rb;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    #3;
    checkResetState("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    runOp(8'd100, 8'd7, "t100by7");

    // Outputs hold while idle
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_ready", 32'(bus.ready), 32'd1);
    checkHeld("idle");

    // Asynchronous reset pulse in the middle of idle, away from any edge
    #2;
    rst = 1'b1;
    #1;
    checkResetState("asyncIdle");
    #1;
    rst = 1'b0;

    runOp(8'd255, 8'd1, "t255by1");
    runOp(8'd5, 8'd9, "t5by9");
    runOp(8'd77, 8'd0, "t77by0");
    runOp(8'd60, 8'd6, "clearDbz");

    // Restart at iteration 3 with new operands
    applyStimulus(8'd50, 8'd3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("restart_midBusy", 32'(bus.ready), 32'd0);
    applyStimulus(8'd200, 8'd10);
    finishOp(8'd200, 8'd10, "restart");

    // Reset at iteration 4 abandons the operation
    applyStimulus(8'd123, 8'd45);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkResetState("asyncBusy");
    #1;
    rst = 1'b0;
    runOp(8'd123, 8'd45, "afterRst");

    // Randomized sweep, including zero and one divisors now and then
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 8'd1;
        2:       rb = ra;
        default: rb = WIDTH'($urandom);
      endcase
      runOp(ra, rb, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
